// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX stage:
// forwarding selects, ALU codes and the bubble bundle.
package id_ex_stage_pkg;

  localparam logic [4:0] ALU_ADDU = 5'd1;

  localparam logic [1:0] FWD_NONE = 2'd0;
  localparam logic [1:0] FWD_MEM  = 2'd1;
  localparam logic [1:0] FWD_WB   = 2'd2;

  typedef struct packed {
    logic       valid;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic [4:0] shamt;
    logic [4:0] alu_ctl;
  } id_ex_ctrl_t;

  localparam id_ex_ctrl_t ID_EX_CTRL_BUBBLE = '{
    valid:      1'b0,
    reg_write:  1'b0,
    mem_read:   1'b0,
    mem_write:  1'b0,
    mem_to_reg: 1'b0,
    alu_src:    1'b0,
    shamt:      5'd0,
    alu_ctl:    ALU_ADDU
  };

endpackage

// File: rtl/id_ex_stage_fwd_unit.sv
// Per-operand forwarding select; MEM beats WB,
// register 0 never forwards.
module fwd_unit
  import id_ex_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] src,
  input  logic              mem_reg_write,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              wb_reg_write,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  output logic [1:0]        sel,
  output logic [DATA_W-1:0] data
);

  logic mem_hit;
  logic wb_hit;

  assign mem_hit = mem_reg_write
                 & (mem_rd != '0)
                 & (mem_rd == src);
  assign wb_hit  = wb_reg_write
                 & (wb_rd != '0)
                 & (wb_rd == src);

  always_comb begin
    sel  = FWD_NONE;
    data = '0;
    if (mem_hit) begin
      sel  = FWD_MEM;
      data = mem_data;
    end else if (wb_hit) begin
      sel  = FWD_WB;
      data = wb_data;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with MEM/WB forwarding,
// load-use stall, branch flush and global hold.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              Hold,
  input  logic              Flush,
  input  logic              ID_Valid,
  input  logic [DATA_W-1:0] ID_RsData,
  input  logic [DATA_W-1:0] ID_RtData,
  input  logic [REG_AW-1:0] ID_Rs,
  input  logic [REG_AW-1:0] ID_Rt,
  input  logic [REG_AW-1:0] ID_Rd,
  input  logic [DATA_W-1:0] ID_Imm,
  input  logic [4:0]        ID_Shamt,
  input  logic [4:0]        ID_ALUControl,
  input  logic              ID_ALUSrc,
  input  logic              ID_RegWrite,
  input  logic              ID_MemRead,
  input  logic              ID_MemWrite,
  input  logic              ID_MemToReg,
  input  logic              MEM_RegWrite,
  input  logic [REG_AW-1:0] MEM_Rd,
  input  logic [DATA_W-1:0] MEM_ALUResult,
  input  logic              WB_RegWrite,
  input  logic [REG_AW-1:0] WB_Rd,
  input  logic [DATA_W-1:0] WB_Data,
  output logic              Stall,
  output logic [DATA_W-1:0] OperandA,
  output logic [DATA_W-1:0] OperandB,
  output logic [4:0]        Shamt,
  output logic [4:0]        ALUControl,
  output logic [DATA_W-1:0] EX_StoreData,
  output logic [REG_AW-1:0] EX_Rd,
  output logic              EX_Valid,
  output logic              EX_RegWrite,
  output logic              EX_MemRead,
  output logic              EX_MemWrite,
  output logic              EX_MemToReg
);

  id_ex_ctrl_t       ctrl_q;
  logic [REG_AW-1:0] rd_q;
  logic [REG_AW-1:0] rs_q;
  logic [REG_AW-1:0] rt_q;
  logic [DATA_W-1:0] rs_data_q;
  logic [DATA_W-1:0] rt_data_q;
  logic [DATA_W-1:0] imm_q;

  id_ex_ctrl_t ctrl_d;
  logic        bubble;

  assign ctrl_d = '{
    valid:      ID_Valid,
    reg_write:  ID_RegWrite,
    mem_read:   ID_MemRead,
    mem_write:  ID_MemWrite,
    mem_to_reg: ID_MemToReg,
    alu_src:    ID_ALUSrc,
    shamt:      ID_Shamt,
    alu_ctl:    ID_ALUControl
  };

  assign Stall = ctrl_q.valid
               & ctrl_q.mem_read
               & (rd_q != '0)
               & ID_Valid
               & ((rd_q == ID_Rs)
                | (rd_q == ID_Rt))
               & ~Flush;

  assign bubble = Flush | Stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q    <= ID_EX_CTRL_BUBBLE;
      rd_q      <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
      rs_data_q <= '0;
      rt_data_q <= '0;
      imm_q     <= '0;
    end else if (!Hold) begin
      if (bubble) begin
        ctrl_q    <= ID_EX_CTRL_BUBBLE;
        rd_q      <= '0;
        rs_q      <= '0;
        rt_q      <= '0;
        rs_data_q <= '0;
        rt_data_q <= '0;
        imm_q     <= '0;
      end else begin
        ctrl_q    <= ctrl_d;
        rd_q      <= ID_Rd;
        rs_q      <= ID_Rs;
        rt_q      <= ID_Rt;
        rs_data_q <= ID_RsData;
        rt_data_q <= ID_RtData;
        imm_q     <= ID_Imm;
      end
    end
  end

  logic [1:0]        sel_a;
  logic [1:0]        sel_b;
  logic [DATA_W-1:0] fwd_a;
  logic [DATA_W-1:0] fwd_b;
  logic [DATA_W-1:0] rs_val;
  logic [DATA_W-1:0] rt_val;

  fwd_unit #(
    .DATA_W(DATA_W),
    .REG_AW(REG_AW)
  ) u_fwd_rs (
    .src          (rs_q),
    .mem_reg_write(MEM_RegWrite),
    .mem_rd       (MEM_Rd),
    .mem_data     (MEM_ALUResult),
    .wb_reg_write (WB_RegWrite),
    .wb_rd        (WB_Rd),
    .wb_data      (WB_Data),
    .sel          (sel_a),
    .data         (fwd_a)
  );

  fwd_unit #(
    .DATA_W(DATA_W),
    .REG_AW(REG_AW)
  ) u_fwd_rt (
    .src          (rt_q),
    .mem_reg_write(MEM_RegWrite),
    .mem_rd       (MEM_Rd),
    .mem_data     (MEM_ALUResult),
    .wb_reg_write (WB_RegWrite),
    .wb_rd        (WB_Rd),
    .wb_data      (WB_Data),
    .sel          (sel_b),
    .data         (fwd_b)
  );

  assign rs_val = (sel_a == FWD_NONE)
                ? rs_data_q : fwd_a;
  assign rt_val = (sel_b == FWD_NONE)
                ? rt_data_q : fwd_b;

  assign OperandA     = rs_val;
  assign EX_StoreData = rt_val;
  assign OperandB     = ctrl_q.alu_src
                      ? imm_q : rt_val;
  assign Shamt        = ctrl_q.shamt;
  assign ALUControl   = ctrl_q.alu_ctl;
  assign EX_Rd        = rd_q;
  assign EX_Valid     = ctrl_q.valid;
  assign EX_RegWrite  = ctrl_q.reg_write;
  assign EX_MemRead   = ctrl_q.mem_read;
  assign EX_MemWrite  = ctrl_q.mem_write;
  assign EX_MemToReg  = ctrl_q.mem_to_reg;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed hazard
// scenarios followed by randomized traffic.
module tb_id_ex_stage;
  import id_ex_stage_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        Hold, Flush, ID_Valid;
  logic [31:0] ID_RsData, ID_RtData, ID_Imm;
  logic [4:0]  ID_Rs, ID_Rt, ID_Rd;
  logic [4:0]  ID_Shamt, ID_ALUControl;
  logic        ID_ALUSrc, ID_RegWrite;
  logic        ID_MemRead, ID_MemWrite, ID_MemToReg;
  logic        MEM_RegWrite, WB_RegWrite;
  logic [4:0]  MEM_Rd, WB_Rd;
  logic [31:0] MEM_ALUResult, WB_Data;
  logic        Stall;
  logic [31:0] OperandA, OperandB, EX_StoreData;
  logic [4:0]  Shamt, ALUControl, EX_Rd;
  logic        EX_Valid, EX_RegWrite;
  logic        EX_MemRead, EX_MemWrite, EX_MemToReg;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .reset(reset),
    .Hold(Hold), .Flush(Flush),
    .ID_Valid(ID_Valid),
    .ID_RsData(ID_RsData), .ID_RtData(ID_RtData),
    .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_Rd(ID_Rd),
    .ID_Imm(ID_Imm), .ID_Shamt(ID_Shamt),
    .ID_ALUControl(ID_ALUControl),
    .ID_ALUSrc(ID_ALUSrc),
    .ID_RegWrite(ID_RegWrite),
    .ID_MemRead(ID_MemRead),
    .ID_MemWrite(ID_MemWrite),
    .ID_MemToReg(ID_MemToReg),
    .MEM_RegWrite(MEM_RegWrite), .MEM_Rd(MEM_Rd),
    .MEM_ALUResult(MEM_ALUResult),
    .WB_RegWrite(WB_RegWrite), .WB_Rd(WB_Rd),
    .WB_Data(WB_Data),
    .Stall(Stall),
    .OperandA(OperandA), .OperandB(OperandB),
    .Shamt(Shamt), .ALUControl(ALUControl),
    .EX_StoreData(EX_StoreData), .EX_Rd(EX_Rd),
    .EX_Valid(EX_Valid), .EX_RegWrite(EX_RegWrite),
    .EX_MemRead(EX_MemRead),
    .EX_MemWrite(EX_MemWrite),
    .EX_MemToReg(EX_MemToReg)
  );

  typedef struct {
    logic        v, rw, mr, mw, mtr, src;
    logic [4:0]  rd, rs, rt, sh, alu;
    logic [31:0] rsd, rtd, imm;
  } mst_t;

  typedef struct {
    logic [31:0] opa, opb, sd;
    logic [4:0]  sh, alu, rd;
    logic        v, rw, mr, mw, mtr, st;
  } exp_t;

  exp_t q[$];
  mst_t m;
  logic exp_stall;
  int   checks = 0;
  int   errors = 0;

  task automatic cmp(string n, logic [31:0] a,
                     logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h exp %h t=%0t",
               n, a, e, $time);
    end
  endtask

  function automatic mst_t bub();
    mst_t b;
    b = '{default: '0};
    b.alu = ALU_ADDU;
    return b;
  endfunction

  function automatic logic [31:0] fwd(
      logic [4:0] r, logic [31:0] d);
    if (MEM_RegWrite && MEM_Rd != 0 && MEM_Rd == r)
      return MEM_ALUResult;
    if (WB_RegWrite && WB_Rd != 0 && WB_Rd == r)
      return WB_Data;
    return d;
  endfunction

  task automatic idle();
    reset = 0; Hold = 0; Flush = 0; ID_Valid = 0;
    ID_RsData = 0; ID_RtData = 0; ID_Imm = 0;
    ID_Rs = 0; ID_Rt = 0; ID_Rd = 0;
    ID_Shamt = 0; ID_ALUControl = ALU_ADDU;
    ID_ALUSrc = 0; ID_RegWrite = 0;
    ID_MemRead = 0; ID_MemWrite = 0; ID_MemToReg = 0;
    MEM_RegWrite = 0; MEM_Rd = 0; MEM_ALUResult = 0;
    WB_RegWrite = 0; WB_Rd = 0; WB_Data = 0;
  endtask

  task automatic begin_cycle();
    @(negedge clk);
    idle();
  endtask

  task automatic settle();
    exp_t e;
    logic [31:0] b;
    #1;
    b = fwd(m.rt, m.rtd);
    e.opa = fwd(m.rs, m.rsd);
    e.sd  = b;
    e.opb = m.src ? m.imm : b;
    e.sh = m.sh; e.alu = m.alu; e.rd = m.rd;
    e.v = m.v; e.rw = m.rw; e.mr = m.mr;
    e.mw = m.mw; e.mtr = m.mtr;
    e.st = m.v && m.mr && m.rd != 0 && ID_Valid
        && (m.rd == ID_Rs || m.rd == ID_Rt)
        && !Flush;
    exp_stall = e.st;
    q.push_back(e);
  endtask

  task automatic commit();
    @(posedge clk);
    if (reset) m = bub();
    else if (Hold) m = m;
    else if (Flush || exp_stall) m = bub();
    else begin
      m.v = ID_Valid; m.rw = ID_RegWrite;
      m.mr = ID_MemRead; m.mw = ID_MemWrite;
      m.mtr = ID_MemToReg; m.src = ID_ALUSrc;
      m.rd = ID_Rd; m.rs = ID_Rs; m.rt = ID_Rt;
      m.sh = ID_Shamt; m.alu = ID_ALUControl;
      m.rsd = ID_RsData; m.rtd = ID_RtData;
      m.imm = ID_Imm;
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        cmp("sb_opa", OperandA, e.opa);
        cmp("sb_opb", OperandB, e.opb);
        cmp("sb_store", EX_StoreData, e.sd);
        cmp("sb_shamt", 32'(Shamt), 32'(e.sh));
        cmp("sb_alu", 32'(ALUControl), 32'(e.alu));
        cmp("sb_rd", 32'(EX_Rd), 32'(e.rd));
        cmp("sb_ctrl",
            {EX_Valid, EX_RegWrite, EX_MemRead,
             EX_MemWrite, EX_MemToReg},
            {e.v, e.rw, e.mr, e.mw, e.mtr});
        cmp("sb_stall", 32'(Stall), 32'(e.st));
      end
    end
  end

  initial begin : driver
    idle();
    reset = 1;
    commit();
    for (int i = 0; i < 2; i++) begin
      begin_cycle(); reset = 1;
      settle(); commit();
    end

    begin_cycle(); settle();
    cmp("rst_valid", 32'(EX_Valid), 0);
    cmp("rst_regwr", 32'(EX_RegWrite), 0);
    cmp("rst_alu", 32'(ALUControl), 32'(ALU_ADDU));
    cmp("rst_opa", OperandA, 0);
    cmp("rst_opb", OperandB, 0);
    cmp("rst_stall", 32'(Stall), 0);
    commit();

    begin_cycle();
    ID_Valid = 1; ID_Rs = 1; ID_Rt = 2; ID_Rd = 3;
    ID_RsData = 5; ID_RtData = 7; ID_RegWrite = 1;
    settle(); commit();
    begin_cycle(); settle();
    cmp("add_opa", OperandA, 5);
    cmp("add_opb", OperandB, 7);
    cmp("add_rd", 32'(EX_Rd), 3);
    cmp("add_regwr", 32'(EX_RegWrite), 1);
    commit();

    begin_cycle();
    ID_Valid = 1; ID_Rs = 1; ID_Rd = 5;
    ID_RegWrite = 1;
    settle(); commit();
    begin_cycle();
    Hold = 1;
    MEM_RegWrite = 1; MEM_Rd = 1;
    MEM_ALUResult = 32'h10;
    WB_RegWrite = 1; WB_Rd = 1; WB_Data = 32'h20;
    settle();
    cmp("fwd_mem", OperandA, 32'h10);
    commit();
    begin_cycle();
    Hold = 1;
    MEM_Rd = 1; MEM_ALUResult = 32'h10;
    WB_RegWrite = 1; WB_Rd = 1; WB_Data = 32'h20;
    settle();
    cmp("fwd_wb", OperandA, 32'h20);
    commit();

    begin_cycle();
    ID_Valid = 1; ID_Rs = 2; ID_Rd = 4;
    ID_MemRead = 1; ID_RegWrite = 1;
    ID_MemToReg = 1; ID_ALUSrc = 1; ID_Imm = 8;
    settle(); commit();
    for (int i = 0; i < 2; i++) begin
      begin_cycle();
      ID_Valid = 1; ID_Rs = 4; ID_Rt = 6;
      ID_Rd = 8; ID_RegWrite = 1;
      settle();
      if (i == 0) begin
        cmp("lu_stall", 32'(Stall), 1);
      end else begin
        cmp("lu_stall_once", 32'(Stall), 0);
        cmp("lu_bub_valid", 32'(EX_Valid), 0);
        cmp("lu_bub_regwr", 32'(EX_RegWrite), 0);
      end
      commit();
    end
    begin_cycle(); settle();
    cmp("lu_dep_valid", 32'(EX_Valid), 1);
    cmp("lu_dep_rd", 32'(EX_Rd), 8);
    commit();

    begin_cycle();
    ID_Valid = 1; ID_Rd = 7; ID_RegWrite = 1;
    settle(); commit();
    for (int i = 0; i < 3; i++) begin
      begin_cycle();
      Hold = 1; Flush = (i == 1);
      ID_Valid = 1; ID_Rd = 5'(9 + i);
      ID_RsData = $urandom; ID_RegWrite = 1;
      settle();
      cmp("hold_rd", 32'(EX_Rd), 7);
      cmp("hold_valid", 32'(EX_Valid), 1);
      commit();
    end
    begin_cycle();
    Flush = 1; ID_Valid = 1; ID_Rd = 12;
    ID_RegWrite = 1;
    settle(); commit();
    begin_cycle(); settle();
    cmp("flush_valid", 32'(EX_Valid), 0);
    cmp("flush_rd", 32'(EX_Rd), 0);
    commit();

    begin_cycle();
    ID_Valid = 1; ID_Rs = 0; ID_RsData = 0;
    ID_Rd = 1; ID_RegWrite = 1;
    settle(); commit();
    begin_cycle();
    MEM_RegWrite = 1; MEM_Rd = 0;
    MEM_ALUResult = 32'hDEAD;
    settle();
    cmp("r0_nofwd", OperandA, 0);
    commit();

    for (int i = 0; i < 400; i++) begin
      begin_cycle();
      reset = ($urandom_range(0, 63) == 0);
      Hold = ($urandom_range(0, 7) == 0);
      Flush = ($urandom_range(0, 7) == 0);
      ID_Valid = ($urandom_range(0, 7) != 0);
      ID_RsData = $urandom; ID_RtData = $urandom;
      ID_Imm = $urandom;
      ID_Rs = 5'($urandom_range(0, 3));
      ID_Rt = 5'($urandom_range(0, 3));
      ID_Rd = 5'($urandom_range(0, 3));
      ID_Shamt = 5'($urandom);
      ID_ALUControl = 5'($urandom);
      ID_ALUSrc = 1'($urandom);
      ID_RegWrite = 1'($urandom);
      ID_MemRead = ($urandom_range(0, 2) == 0);
      ID_MemWrite = 1'($urandom);
      ID_MemToReg = 1'($urandom);
      MEM_RegWrite = 1'($urandom);
      MEM_Rd = 5'($urandom_range(0, 3));
      MEM_ALUResult = $urandom;
      WB_RegWrite = 1'($urandom);
      WB_Rd = 5'($urandom_range(0, 3));
      WB_Data = $urandom;
      settle(); commit();
    end

    begin_cycle();
    repeat (2) @(negedge clk);
    cmp("sb_drained", 32'(q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
